// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: next-PC selection, PC/IF-ID stall, pipeline flushes and bounded fetch wait.
// Optional trap redirect is compiled in when PC_SEQ_TRAP_EN is defined.
module pc_sequencer #(
  parameter logic [63:0] RESET_VECTOR = 64'h0,
  parameter int unsigned MAX_WAIT     = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] pc_cur,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic        load_use_stall,
  input  logic        imem_ready,
`ifdef PC_SEQ_TRAP_EN
  input  logic        trap_req,
  input  logic [63:0] trap_vector,
  output logic [63:0] trap_epc,
`endif
  output logic        imem_req,
  output logic [63:0] pc_next,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        fetch_timeout,
  output logic [15:0] redirect_count
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } state_e;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        fetch_timeout_q, fetch_timeout_d;
  logic [15:0] redirect_count_q, redirect_count_d;
  logic        trap_sel;
  logic [63:0] trap_target;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

`ifdef PC_SEQ_TRAP_EN
  logic [63:0] trap_epc_q, trap_epc_d;
  assign trap_sel    = trap_req;
  assign trap_target = trap_vector;
  assign trap_epc    = trap_epc_q;
`else
  assign trap_sel    = 1'b0;
  assign trap_target = 64'h0;
`endif

  // Registered state: FSM, wait counter, sticky timeout, redirect counter, trap EPC
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= BOOT;
      wait_cnt_q       <= 8'd0;
      fetch_timeout_q  <= 1'b0;
      redirect_count_q <= 16'd0;
`ifdef PC_SEQ_TRAP_EN
      trap_epc_q       <= 64'h0;
`endif
    end else begin
      state_q          <= state_d;
      wait_cnt_q       <= wait_cnt_d;
      fetch_timeout_q  <= fetch_timeout_d;
      redirect_count_q <= redirect_count_d;
`ifdef PC_SEQ_TRAP_EN
      trap_epc_q       <= trap_epc_d;
`endif
    end
  end

  // Mealy next-state and control outputs
  always_comb begin
    state_d          = state_q;
    wait_cnt_d       = wait_cnt_q;
    fetch_timeout_d  = fetch_timeout_q;
    redirect_count_d = redirect_count_q;
`ifdef PC_SEQ_TRAP_EN
    trap_epc_d       = trap_epc_q;
`endif
    imem_req         = 1'b0;
    pc_next          = pc_cur;
    pc_stall         = 1'b1;
    if_id_stall      = 1'b0;
    if_id_flush      = 1'b0;
    id_ex_flush      = 1'b0;

    unique case (state_q)
      BOOT: begin
        pc_next     = RESET_VECTOR;
        pc_stall    = 1'b0;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        state_d     = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (trap_sel || branch_taken) begin
          pc_next     = trap_sel ? trap_target : branch_target;
          pc_stall    = 1'b0;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          wait_cnt_d  = 8'd0;
          // A response still pending for the old PC must be discarded first
          state_d     = imem_ready ? FETCH : DRAIN;
          if (!trap_sel) begin
            redirect_count_d = sat_inc16(redirect_count_q);
          end
`ifdef PC_SEQ_TRAP_EN
          if (trap_sel) begin
            trap_epc_d = pc_cur;
          end
`endif
        end else if (load_use_stall) begin
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end else if (!imem_ready) begin
          if_id_flush = 1'b1;
          wait_cnt_d  = wait_cnt_q + 8'd1;
          if (wait_cnt_d == MAX_WAIT_C) begin
            fetch_timeout_d = 1'b1;
            state_d         = HALT;
          end
        end else begin
          pc_next    = pc_cur + 64'd4;
          pc_stall   = 1'b0;
          wait_cnt_d = 8'd0;
        end
      end
      DRAIN: begin
        if_id_flush = 1'b1;
        if (imem_ready) begin
          state_d = FETCH;
        end
      end
      HALT: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      default: state_d = BOOT;
    endcase
  end

  assign fetch_timeout  = fetch_timeout_q;
  assign redirect_count = redirect_count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with an external PC register model; trap checks under PC_SEQ_TRAP_EN.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] pc_cur;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        load_use_stall;
  logic        imem_ready;
  logic        imem_req;
  logic [63:0] pc_next;
  logic        pc_stall;
  logic        if_id_stall;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        fetch_timeout;
  logic [15:0] redirect_count;
`ifdef PC_SEQ_TRAP_EN
  logic        trap_req;
  logic [63:0] trap_vector;
  logic [63:0] trap_epc;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_pc;

  always #5 clk = ~clk;

  pc_sequencer #(
    .RESET_VECTOR(64'h1000),
    .MAX_WAIT    (8)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pc_cur        (pc_cur),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .load_use_stall(load_use_stall),
    .imem_ready    (imem_ready),
`ifdef PC_SEQ_TRAP_EN
    .trap_req      (trap_req),
    .trap_vector   (trap_vector),
    .trap_epc      (trap_epc),
`endif
    .imem_req      (imem_req),
    .pc_next       (pc_next),
    .pc_stall      (pc_stall),
    .if_id_stall   (if_id_stall),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .fetch_timeout (fetch_timeout),
    .redirect_count(redirect_count)
  );

  // PC register driven by the sequencer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc_cur <= 64'h0;
    else if (!pc_stall) pc_cur <= pc_next;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n        = 1'b0;
    branch_taken   = 1'b0;
    branch_target  = 64'h0;
    load_use_stall = 1'b0;
    imem_ready     = 1'b1;
`ifdef PC_SEQ_TRAP_EN
    trap_req       = 1'b0;
    trap_vector    = 64'h0;
`endif
    step();
    step();
    check("rst_pc_next", pc_next, 64'h1000);
    check("rst_imem_req", imem_req, 0);
    check("rst_flushes", {if_id_flush, id_ex_flush}, 2'b11);
    check("rst_timeout", fetch_timeout, 0);
    check("rst_redir_cnt", redirect_count, 0);
`ifdef PC_SEQ_TRAP_EN
    check("rst_trap_epc", trap_epc, 0);
`endif
    reset_n = 1'b1;

    // Sequential fetch from the reset vector
    step(); #1;
    check("seq_pc0", pc_cur, 64'h1000);
    check("seq_imem_req", imem_req, 1);
    check("seq_next0", pc_next, 64'h1004);
    check("seq_ctrl0", {pc_stall, if_id_stall, if_id_flush, id_ex_flush}, 4'b0000);
    step(); #1;
    check("seq_pc1", pc_cur, 64'h1004);

    // Two-cycle load-use stall at 1004
    load_use_stall = 1'b1; #1;
    for (int i = 0; i < 2; i++) begin
      check("lu_ctrl", {pc_stall, if_id_stall, if_id_flush, id_ex_flush}, 4'b1101);
      check("lu_pc_next", pc_next, 64'h1004);
      step(); #1;
    end
    load_use_stall = 1'b0; #1;
    check("lu_release", {pc_stall, pc_next}, {1'b0, 64'h1008});
    step(); #1;
    check("seq_pc2", pc_cur, 64'h1008);

    // Branch with concurrent load-use stall: branch wins
    branch_taken = 1'b1; branch_target = 64'h2000; load_use_stall = 1'b1; #1;
    check("br_pc_next", pc_next, 64'h2000);
    check("br_ctrl", {pc_stall, if_id_stall, if_id_flush, id_ex_flush}, 4'b0011);
    step();
    branch_taken = 1'b0; load_use_stall = 1'b0; #1;
    check("br_count", redirect_count, 1);
    check("br_pc", pc_cur, 64'h2000);
    check("br_fetch", {imem_req, pc_next}, {1'b1, 64'h2004});

    // Branch while imem is busy: DRAIN until the stale response arrives
    branch_taken = 1'b1; branch_target = 64'h3000; imem_ready = 1'b0; #1;
    check("brd_pc_next", {pc_stall, pc_next}, {1'b0, 64'h3000});
    step();
    branch_target = 64'h4000; #1;
    check("drain_cnt", redirect_count, 2);
    check("drain_pc", pc_cur, 64'h3000);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) imem_ready = 1'b1;
      #1;
      check("drain_ctrl", {imem_req, pc_stall, if_id_flush}, 3'b011);
      check("drain_pc_next", pc_next, 64'h3000);
      step();
    end
    branch_taken = 1'b0; #1;
    check("drain_exit", {imem_req, pc_next}, {1'b1, 64'h3004});
    check("drain_ign_cnt", redirect_count, 2);
    exp_pc = 64'h3000;

`ifdef PC_SEQ_TRAP_EN
    trap_req = 1'b1; trap_vector = 64'h8000;
    branch_taken = 1'b1; branch_target = 64'h5000; #1;
    check("trap_pc_next", pc_next, 64'h8000);
    check("trap_flush", {pc_stall, if_id_flush, id_ex_flush}, 3'b011);
    step();
    trap_req = 1'b0; branch_taken = 1'b0; #1;
    check("trap_epc", trap_epc, 64'h3000);
    check("trap_cnt", redirect_count, 2);
    check("trap_pc", pc_cur, 64'h8000);
    exp_pc = 64'h8000;
`endif

    // Seven waits then a ready cycle must restart the wait budget
    imem_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      #1;
      check("wait_ctrl", {pc_stall, if_id_flush, pc_next}, {2'b11, exp_pc});
      step();
    end
    check("wait7_timeout", fetch_timeout, 0);
    imem_ready = 1'b1; #1;
    check("wait_resume", {pc_stall, pc_next}, {1'b0, exp_pc + 64'd4});
    step();
    exp_pc = exp_pc + 64'd4;
    imem_ready = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("wait_no_timeout", fetch_timeout, 0);
    check("wait_still_req", imem_req, 1);
    step();
    check("timeout_set", fetch_timeout, 1);
    check("halt_ctrl", {imem_req, pc_stall, if_id_flush, id_ex_flush}, 4'b0111);
    check("halt_pc", pc_cur, exp_pc);
    imem_ready = 1'b1;
    step();
    check("halt_hold", {fetch_timeout, imem_req, pc_stall}, 3'b101);

    // Reset out of HALT restarts at the reset vector
    reset_n = 1'b0; #1;
    check("rst2_timeout", fetch_timeout, 0);
    check("rst2_cnt", redirect_count, 0);
    check("rst2_pc_next", pc_next, 64'h1000);
    reset_n = 1'b1;
    step();
    check("rst2_pc", pc_cur, 64'h1000);

    // PC increment wraps at the top of the address space
    branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC; #1;
    step();
    branch_taken = 1'b0; #1;
    check("wrap_pc", pc_cur, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_next", pc_next, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
